// File: rtl/snn_pe_pkg.sv
// Shared definitions for the SNN convolution PE.
// Holds the packet field layout helpers, packet type codes, the PE state
// encoding and the saturating adder used by the integrate-and-fire neuron.
package snn_pe_pkg;

  // Packet type bit values (MSB of every packet)
  localparam logic TYPE_FILTER = 1'b0;
  localparam logic TYPE_IFMAP  = 1'b1;

  // Packet layout, MSB first: {type, dest, src, payload}
  function automatic int unsigned pkt_src_lsb(input int unsigned pay_w);
    return pay_w;
  endfunction

  function automatic int unsigned pkt_dest_lsb(input int unsigned pay_w,
                                               input int unsigned addr_w);
    return pay_w + addr_w;
  endfunction

  function automatic int unsigned pkt_type_bit(input int unsigned pay_w,
                                               input int unsigned addr_w);
    return pay_w + 2 * addr_w;
  endfunction

  typedef enum logic [1:0] {S_LOAD, S_MAC, S_FIRE, S_SEND} state_e;

  // Unsigned add clamped to 2^w-1 (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (s > lim) ? lim[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/snn_if_neuron.sv
// Integrate-and-fire neuron with subtract-reset and a persistent membrane.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clear     zero the membrane (new filter loaded)
//   fire      integrate acc into the membrane this cycle
//   acc       MAC result for the current timestep
//   spike     combinational fire decision for membrane+acc (valid while fire is high)
module snn_if_neuron
  import snn_pe_pkg::*;
#(
  parameter int unsigned MEM_W = 12,
  parameter int unsigned ACC_W = 12,
  parameter int unsigned VT    = 49
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             fire,
  input  logic [ACC_W-1:0] acc,
  output logic             spike
);

  localparam logic [MEM_W-1:0] VT_M = MEM_W'(VT);

  logic [MEM_W-1:0] membrane_q;
  logic [MEM_W-1:0] sum;

  // Saturation happens before the threshold subtraction.
  assign sum   = MEM_W'(sat_add(32'(membrane_q), 32'(acc), MEM_W));
  assign spike = sum > VT_M;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      membrane_q <= '0;
    end else if (clear) begin
      membrane_q <= '0;
    end else if (fire) begin
      membrane_q <= spike ? sum - VT_M : sum;
    end
  end

endmodule

// File: rtl/snn_conv_pe.sv
// SNN convolution processing element.
// Depacketises K filter rows and K binary ifmap rows, runs one weight x spike
// MAC per cycle over the KxK window, integrates into the neuron and sends one
// result packet per timestep to the memory wrapper.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_pkt/valid/ready   NoC input {type, dest, src, payload}
//   out_pkt/valid/ready  NoC output {0, MEM_ADDR, PE_ADDR, {.., ts, spike}}
//   busy                 high whenever the PE is not in S_LOAD
module snn_conv_pe
  import snn_pe_pkg::*;
#(
  parameter int unsigned       K        = 3,
  parameter int unsigned       W_W      = 8,
  parameter int unsigned       MEM_W    = 12,
  parameter int unsigned       VT       = 49,
  parameter int unsigned       ADDR_W   = 4,
  parameter logic [ADDR_W-1:0] PE_ADDR  = 4'b0000,
  parameter logic [ADDR_W-1:0] MEM_ADDR = 4'b1101,
  parameter int unsigned       T_W      = 8,
  parameter int unsigned       PKT_W    = 1 + 2 * ADDR_W + K * W_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PKT_W-1:0] in_pkt,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PKT_W-1:0] out_pkt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned PAY_W    = K * W_W;
  localparam int unsigned N        = K * K;
  localparam int unsigned IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ACC_W    = W_W + IDX_W;
  localparam int unsigned ROW_W    = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned TYPE_BIT = pkt_type_bit(PAY_W, ADDR_W);
  localparam int unsigned SRC_LSB  = pkt_src_lsb(PAY_W);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(K - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_e           state_q;
  logic [ROW_W-1:0] frow_q;
  logic [ROW_W-1:0] irow_q;
  logic [IDX_W-1:0] idx_q;
  logic [ACC_W-1:0] acc_q;
  logic [T_W-1:0]   ts_q;
  logic             filter_ok_q;
  logic [W_W-1:0]   weights_q [N];
  logic [N-1:0]     spikes_q;

  logic             in_type;
  logic [PAY_W-1:0] payload;
  logic             accept;
  logic [ACC_W-1:0] mac_term;
  logic             neuron_clear;
  logic             neuron_fire;
  logic             fire_spike;
  logic [PAY_W-1:0] res_payload;
  logic             unused_addr;

  assign in_type     = in_pkt[TYPE_BIT];
  assign payload     = in_pkt[PAY_W-1:0];
  // Routing fields were consumed by the router; the PE does not check them.
  assign unused_addr = ^in_pkt[TYPE_BIT-1:SRC_LSB];

  // Filters may only replace weights between ifmap windows; ifmaps need a
  // complete filter. Anything else stalls on the port.
  assign in_ready = (state_q == S_LOAD) &&
                    ((in_type == TYPE_IFMAP) ? filter_ok_q : (irow_q == '0));
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != S_LOAD);

  assign mac_term     = spikes_q[idx_q] ? ACC_W'(weights_q[idx_q]) : '0;
  assign neuron_clear = accept && (in_type == TYPE_FILTER) && (frow_q == LAST_ROW);
  assign neuron_fire  = (state_q == S_FIRE);

  always_comb begin
    res_payload        = '0;
    res_payload[T_W:0] = {ts_q, fire_spike};
  end

  snn_if_neuron #(
    .MEM_W (MEM_W),
    .ACC_W (ACC_W),
    .VT    (VT)
  ) u_neuron (
    .clk   (clk),
    .rst   (rst),
    .clear (neuron_clear),
    .fire  (neuron_fire),
    .acc   (acc_q),
    .spike (fire_spike)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      frow_q      <= '0;
      irow_q      <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      ts_q        <= '0;
      filter_ok_q <= 1'b0;
      spikes_q    <= '0;
      for (int n = 0; n < N; n++) weights_q[n] <= '0;
      out_valid   <= 1'b0;
      out_pkt     <= '0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (accept) begin
            if (in_type == TYPE_FILTER) begin
              for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                  if (frow_q == ROW_W'(r)) weights_q[r*K+c] <= payload[c*W_W +: W_W];
                end
              end
              // Row 0 of a new filter invalidates the old one until its last row.
              if (frow_q == '0) filter_ok_q <= 1'b0;
              if (frow_q == LAST_ROW) begin
                filter_ok_q <= 1'b1;
                ts_q        <= '0;
                frow_q      <= '0;
              end else begin
                frow_q <= frow_q + 1'b1;
              end
            end else begin
              for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                  if (irow_q == ROW_W'(r)) spikes_q[r*K+c] <= payload[c];
                end
              end
              if (irow_q == LAST_ROW) begin
                irow_q  <= '0;
                idx_q   <= '0;
                acc_q   <= '0;
                state_q <= S_MAC;
              end else begin
                irow_q <= irow_q + 1'b1;
              end
            end
          end
        end
        S_MAC: begin
          acc_q <= acc_q + mac_term;
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            state_q <= S_FIRE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_FIRE: begin
          out_pkt <= {TYPE_FILTER, MEM_ADDR, PE_ADDR, res_payload};
          ts_q    <= ts_q + 1'b1;
          acc_q   <= '0;
          state_q <= S_SEND;
        end
        S_SEND: begin
          // The packet is latched in S_FIRE and presented one cycle later.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= S_LOAD;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_conv_pe.sv
module tb_snn_conv_pe;

  localparam int unsigned PKT_W = 33;

  logic             clk;
  logic             rst;
  logic [PKT_W-1:0] in_pkt;
  logic             in_valid;
  logic             in_ready;
  logic [PKT_W-1:0] out_pkt;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [PKT_W-1:0] sb_q[$];

  // Reference model state
  int         mw[9];
  int         mem_m;
  logic [7:0] ts_m;

  snn_conv_pe u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_pkt    (in_pkt),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_pkt   (out_pkt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [PKT_W-1:0] mk_filter(input logic [23:0] row);
    return {1'b0, 4'b0000, 4'b1101, row};
  endfunction

  function automatic logic [PKT_W-1:0] mk_ifmap(input logic [2:0] bits);
    return {1'b1, 4'b0000, 4'b1101, 21'h1ABCDE, bits};
  endfunction

  // Output monitor: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check_eq("sb_pop", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) check_eq("out_pkt", 64'(out_pkt), 64'(sb_q.pop_front()));
    end
  end

  task automatic send_pkt(input logic [PKT_W-1:0] pkt, input string tag);
    int n;
    bit ok;
    in_pkt   = pkt;
    in_valid = 1'b1;
    n        = 0;
    ok       = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      n++;
    end
    check_eq({tag, "_accept"}, 64'(ok), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic present_stall(input logic [PKT_W-1:0] pkt, input string tag);
    int n;
    in_pkt   = pkt;
    in_valid = 1'b1;
    n        = 0;
    repeat (5) begin
      @(negedge clk);
      if (!in_ready) n++;
    end
    check_eq(tag, 64'(n), 64'd5);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic load_filter(input logic [23:0] f0, input logic [23:0] f1, input logic [23:0] f2);
    for (int c = 0; c < 3; c++) begin
      mw[c]   = int'(f0[c*8 +: 8]);
      mw[3+c] = int'(f1[c*8 +: 8]);
      mw[6+c] = int'(f2[c*8 +: 8]);
    end
    mem_m = 0;
    ts_m  = 8'd0;
    send_pkt(mk_filter(f0), "filt0");
    send_pkt(mk_filter(f1), "filt1");
    send_pkt(mk_filter(f2), "filt2");
  endtask

  task automatic run_step(input logic [2:0] r0, input logic [2:0] r1, input logic [2:0] r2,
                          input bit stall_filter, input bit hold_out);
    logic [2:0]       rows[3];
    logic [PKT_W-1:0] exp_pkt;
    int               acc, sum, cyc;
    bit               sp;
    rows = '{r0, r1, r2};
    acc  = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (rows[r][c]) acc += mw[r*3+c];
    sum = mem_m + acc;
    if (sum > 4095) sum = 4095;
    sp      = (sum > 49);
    mem_m   = sp ? sum - 49 : sum;
    exp_pkt = {1'b0, 4'b1101, 4'b0000, 15'd0, ts_m, sp};
    ts_m    = ts_m + 8'd1;
    sb_q.push_back(exp_pkt);
    if (hold_out) out_ready = 1'b0;

    send_pkt(mk_ifmap(r0), "ifmap0");
    if (stall_filter) present_stall(mk_filter(24'h030201), "filter_stall_irow1");
    send_pkt(mk_ifmap(r1), "ifmap1");
    send_pkt(mk_ifmap(r2), "ifmap2");
    check_eq("busy_mac", 64'(busy), 64'd1);

    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1 cyc++;
    end
    check_eq("latency", 64'(cyc), 64'd11);

    if (hold_out) begin
      in_pkt   = mk_ifmap(3'b111);
      in_valid = 1'b1;
      repeat (20) begin
        @(negedge clk);
        check_eq("hold_pkt", 64'(out_pkt), 64'(exp_pkt));
        check_eq("hold_in_ready", 64'(in_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end

    cyc = 0;
    while (out_valid && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
    end
    check_eq("out_drop", 64'(out_valid), 64'd0);
  endtask

  initial begin
    int saw;
    rst       = 1'b1;
    in_pkt    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_pkt", 64'(out_pkt), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);

    // Ifmap before any filter stalls
    present_stall(mk_ifmap(3'b111), "ifmap_no_filter");

    // Basic three timesteps: 45/no spike, 41/spike, 37/spike
    load_filter(24'h030201, 24'h060504, 24'h090807);
    run_step(3'b111, 3'b111, 3'b111, 1'b0, 1'b0);
    run_step(3'b111, 3'b111, 3'b111, 1'b0, 1'b0);
    run_step(3'b111, 3'b111, 3'b111, 1'b0, 1'b0);

    // Sparse spikes on a nonzero membrane
    run_step(3'b101, 3'b010, 3'b100, 1'b0, 1'b0);

    // Filter stalls while irow=1, then reloads and clears membrane
    run_step(3'b111, 3'b111, 3'b111, 1'b1, 1'b0);
    load_filter(24'h030201, 24'h060504, 24'h090807);
    run_step(3'b111, 3'b111, 3'b111, 1'b0, 1'b0);

    // Output backpressure for 20 cycles
    run_step(3'b111, 3'b111, 3'b111, 1'b0, 1'b1);

    // Reset in the middle of the MAC
    send_pkt(mk_ifmap(3'b111), "rm_ifmap0");
    send_pkt(mk_ifmap(3'b111), "rm_ifmap1");
    send_pkt(mk_ifmap(3'b111), "rm_ifmap2");
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    saw = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) saw++;
    end
    check_eq("rst_mac_no_out", 64'(saw), 64'd0);
    check_eq("rst_mac_busy", 64'(busy), 64'd0);
    present_stall(mk_ifmap(3'b111), "rst_mac_ifmap_stall");
    load_filter(24'h030201, 24'h060504, 24'h090807);
    run_step(3'b111, 3'b111, 3'b111, 1'b0, 1'b0);

    // Saturation: all weights 255, all spikes
    load_filter(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    run_step(3'b111, 3'b111, 3'b111, 1'b0, 1'b0);
    run_step(3'b111, 3'b111, 3'b111, 1'b0, 1'b0);
    run_step(3'b111, 3'b111, 3'b111, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
